// File: rtl/sma_sched_pkg.sv
// Shared types and width helpers for the moving-average channel scheduler.
//   state_e     : FSM states (S_IDLE, S_CALC, S_OUT)
//   log2_taps() : shift amount for the averaging divide
//   acc_width() : accumulator width, DATA_W + log2(TAPS)
//   chan_width(): width of a channel index
package sma_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_OUT
   } state_e;

   function automatic int log2_taps(input int taps);
      return $clog2(taps);
   endfunction

   function automatic int acc_width(input int data_w, input int taps);
      return data_w + $clog2(taps);
   endfunction

   function automatic int chan_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/sma_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one past ptr and
// wraps, so the channel named by ptr has the lowest priority.
//   req    in  CHANNELS   request vector
//   ptr    in  CH_W       last granted channel
//   enable in  1          grant only when high
//   grant  out CHANNELS   one-hot grant (all zero when none)
//   idx    out CH_W       index of the granted channel
module sma_rr_arbiter
   import sma_sched_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int CH_W     = chan_width(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [CH_W-1:0]     ptr,
   input  logic                enable,
   output logic [CHANNELS-1:0] grant,
   output logic [CH_W-1:0]     idx
);

   logic            found;
   logic [CH_W-1:0] c;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      c     = '0;
      for (int k = 1; k <= CHANNELS; k++) begin
         c = CH_W'((int'(ptr) + k) % CHANNELS);
         if (enable && !found && req[c]) begin
            found    = 1'b1;
            grant[c] = 1'b1;
            idx      = c;
         end
      end
   end

endmodule

// File: rtl/sma_channel_sched.sv
// Time-multiplexed simple-moving-average over CHANNELS sample streams.
// Each channel owns a tap history and a running accumulator; a single
// datapath serves the granted channel per transaction.
//   clk, rst      clock; synchronous active-low reset
//   req_valid/req_data/req_ready   per-channel sample handshake (ready is one-hot, combinational)
//   out_valid/out_data/out_chan/out_ready  result handshake
//   busy          FSM not idle
//   flush         per-channel history clear (only with SMA_SCHED_FLUSH_EN defined)
//
// state  | meaning
// S_IDLE | arbitrate, capture granted sample
// S_CALC | update accumulator/history, register result
// S_OUT  | hold result until out_ready
module sma_channel_sched
   import sma_sched_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int DATA_W   = 16,
   parameter int TAPS     = 4
) (
   input  logic                         clk,
   input  logic                         rst,
`ifdef SMA_SCHED_FLUSH_EN
   input  logic [CHANNELS-1:0]          flush,
`endif
   input  logic [CHANNELS-1:0]          req_valid,
   input  logic [CHANNELS*DATA_W-1:0]   req_data,
   output logic [CHANNELS-1:0]          req_ready,
   output logic                         out_valid,
   output logic [DATA_W-1:0]            out_data,
   output logic [chan_width(CHANNELS)-1:0] out_chan,
   input  logic                         out_ready,
   output logic                         busy
);

   localparam int LOG2_TAPS = log2_taps(TAPS);
   localparam int ACC_W     = acc_width(DATA_W, TAPS);
   localparam int CH_W      = chan_width(CHANNELS);

   state_e                    state_q, state_d;
   logic [CH_W-1:0]           ptr_q, ptr_d;
   logic [CH_W-1:0]           gnt_q, gnt_d;
   logic [DATA_W-1:0]         x_q, x_d;
   logic [DATA_W-1:0]         hist_q [CHANNELS][TAPS];
   logic [DATA_W-1:0]         hist_d [CHANNELS][TAPS];
   logic signed [ACC_W-1:0]   acc_q [CHANNELS];
   logic signed [ACC_W-1:0]   acc_d [CHANNELS];
   logic                      out_valid_q, out_valid_d;
   logic [DATA_W-1:0]         out_data_q, out_data_d;
   logic [CH_W-1:0]           out_chan_q, out_chan_d;

   logic [DATA_W-1:0]         req_arr [CHANNELS];
   logic [CHANNELS-1:0]       arb_grant;
   logic [CH_W-1:0]           arb_idx;
   logic [DATA_W-1:0]         oldest;
   logic signed [ACC_W-1:0]   acc_new;

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         req_arr[i] = req_data[i*DATA_W +: DATA_W];
      end
   end

   sma_rr_arbiter #(
      .CHANNELS (CHANNELS),
      .CH_W     (CH_W)
   ) u_arb (
      .req    (req_valid),
      .ptr    (ptr_q),
      .enable (state_q == S_IDLE),
      .grant  (arb_grant),
      .idx    (arb_idx)
   );

   assign req_ready = arb_grant;
   assign oldest    = hist_q[gnt_q][TAPS-1];

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      x_d         = x_q;
      hist_d      = hist_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      acc_new     = '0;

      case (state_q)
         S_IDLE: begin
            if (|arb_grant) begin
               x_d     = req_arr[arb_idx];
               gnt_d   = arb_idx;
               ptr_d   = arb_idx;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            // Sign-extend both taps to accumulator width before the update.
            acc_new = acc_q[gnt_q]
                      - {{LOG2_TAPS{oldest[DATA_W-1]}}, oldest}
                      + {{LOG2_TAPS{x_q[DATA_W-1]}}, x_q};
            hist_d[gnt_q][0] = x_q;
            for (int k = 1; k < TAPS; k++) begin
               hist_d[gnt_q][k] = hist_q[gnt_q][k-1];
            end
            acc_d[gnt_q] = acc_new;
            // Arithmetic shift floors toward -inf; magnitude bound makes truncation safe.
            out_data_d  = DATA_W'(acc_new >>> LOG2_TAPS);
            out_chan_d  = gnt_q;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

`ifdef SMA_SCHED_FLUSH_EN
      // Applied last so a flush overrides a same-cycle writeback.
      for (int i = 0; i < CHANNELS; i++) begin
         if (flush[i]) begin
            acc_d[i] = '0;
            for (int k = 0; k < TAPS; k++) begin
               hist_d[i][k] = '0;
            end
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= CH_W'(CHANNELS-1);
         gnt_q       <= '0;
         x_q         <= '0;
         hist_q      <= '{default: '0};
         acc_q       <= '{default: '0};
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         x_q         <= x_d;
         hist_q      <= hist_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign busy      = (state_q != S_IDLE);

endmodule
